simd_seq_ctrl: RTL and testbench
================================

SIMD_SEQ_CTRL -- requirements
Module: simd_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of PE lanes (1..8).
REQ-002 SHALL have parameter ADDR_W, default 17, operand address width (1..18).
REQ-003 SHALL have parameter TIMEOUT, default 1024, watchdog limit in WAIT cycles (>=2).
REQ-004 SHALL have port CLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RSTN  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port START_SIGNAL  in  1  leaves IDLE.
REQ-007 SHALL have port INSTR  in  32  current instruction: [2:0] opcode, [4:3] dimen, [5] clr, [6+:NUM_PE] lane mask, [31:32-ADDR_W] address.
REQ-008 SHALL have port OP_DONE  in  NUM_PE  per-lane completion pulses.
REQ-009 SHALL have port ABORT  in  1  forces return to IDLE.
REQ-010 SHALL have port PC_INCR  out  1  one-cycle instruction-pointer advance.
REQ-011 SHALL have port OP_START  out  1  one-cycle issue strobe.
REQ-012 SHALL have port OP_CODE  out  3, LANE_EN  out  NUM_PE, ADDRESS  out  ADDR_W, DIMEN  out  2, CLR_ACC  out  1: latched fields of the issued instruction.
REQ-013 SHALL have port INSTR_DONE  out  1  one-cycle completion pulse.
REQ-014 SHALL have port INSTR_CNT  out  16  completed-instruction count.
REQ-015 SHALL have ports BUSY, STOP_SIGNAL, ERR_TIMEOUT  out  1 each: state flags.

Function
REQ-016 SHALL implement states IDLE, FETCH, ISSUE, WAIT, STOP, ERROR; all outputs registered.
REQ-017 IDLE: START_SIGNAL=1 -> FETCH next cycle; else stay.
REQ-018 FETCH (1 cycle): latch opcode/dimen/clr/mask/address; pulse PC_INCR; opcode 0 or 1 (NOP) -> FETCH; 6 -> STOP; 2,3,4,5,7 with nonzero mask -> ISSUE; zero mask -> FETCH as NOP.
REQ-019 ISSUE (1 cycle): OP_START=1 with OP_CODE, LANE_EN, ADDRESS, DIMEN, CLR_ACC valid; -> WAIT.
REQ-020 Latched fields SHALL hold stable from ISSUE until next FETCH.
REQ-021 Per-lane sticky done register SHALL clear in ISSUE and accumulate OP_DONE & LANE_EN from the ISSUE cycle onward; OP_DONE on disabled lanes SHALL be ignored.
REQ-022 WAIT: when (sticky | OP_DONE) & LANE_EN == LANE_EN -> INSTR_DONE=1 one cycle, INSTR_CNT+1 (wraps 0xFFFF->0), next state FETCH.
REQ-023 Latency: START_SIGNAL at t -> FETCH at t+1 -> OP_START at t+2; completion sampled at c -> INSTR_DONE and FETCH at c+1.
REQ-024 STOP: STOP_SIGNAL=1 held; exits only on ABORT or reset.
REQ-025 BUSY SHALL be 1 in FETCH, ISSUE, WAIT; else 0.
REQ-026 ABORT=1 in any non-IDLE state SHALL force IDLE next cycle, clearing STOP_SIGNAL, ERR_TIMEOUT, sticky done; INSTR_CNT retained; ABORT beats completion and timeout.
REQ-027 Back-to-back instructions SHALL be supported: no idle cycle beyond FETCH.

Reset
REQ-028 RSTN=1 SHALL set state IDLE and every output, sticky register and counter to 0, overriding all inputs, in any state.
REQ-029 Reset mid-WAIT SHALL discard the pending instruction without INSTR_DONE.

Configuration
REQ-030 With SIMD_SEQ_WATCHDOG_EN defined: counter clears in ISSUE, increments per WAIT cycle; count reaching TIMEOUT-1 without completion -> ERROR, ERR_TIMEOUT=1 held until ABORT/reset; completion in the same cycle wins.
REQ-031 Without SIMD_SEQ_WATCHDOG_EN: no counter, WAIT unbounded, ERR_TIMEOUT tied 0, ERROR unreachable.

Verification
REQ-032 Reset, START_SIGNAL=1, INSTR opcode 4, mask 4'b1111 -> PC_INCR cycle 1, OP_START cycle 2, all OP_DONE at cycle 5 -> INSTR_DONE cycle 6, INSTR_CNT=1.
REQ-033 Mask 4'b0101, OP_DONE lane0 cycle 3, lane1 cycle 4, lane2 cycle 6 -> INSTR_DONE exactly once, cycle 7; lane1 ignored.
REQ-034 Opcode 0 then opcode 6 -> two PC_INCR pulses, no OP_START, STOP_SIGNAL=1 held 20 cycles; ABORT -> IDLE, STOP_SIGNAL=0.
REQ-035 Watchdog build, TIMEOUT=8, no OP_DONE -> ERR_TIMEOUT=1 after 7 WAIT cycles; same with OP_DONE on the 7th WAIT cycle -> INSTR_DONE, no error.
REQ-036 RSTN=1 mid-WAIT then OP_DONE all lanes -> no INSTR_DONE, outputs 0, state IDLE; INSTR_CNT preloaded 0xFFFF via 65535 NOP-free ops wraps to 0.

Source files
------------

// File: rtl/simd_seq_ctrl_if.sv
// Sequencer bus between the SIMD sequencer and its environment: instruction
// fetch, per-lane completion, abort, and the issued-operation outputs.
interface simd_seq_ctrl_if #(
  parameter int unsigned NUM_PE = 4,
  parameter int unsigned ADDR_W = 17
);

  // Environment -> sequencer
  logic              START_SIGNAL;
  logic [31:0]       INSTR;
  logic [NUM_PE-1:0] OP_DONE;
  logic              ABORT;

  // Sequencer -> environment
  logic              PC_INCR;
  logic              OP_START;
  logic [2:0]        OP_CODE;
  logic [NUM_PE-1:0] LANE_EN;
  logic [ADDR_W-1:0] ADDRESS;
  logic [1:0]        DIMEN;
  logic              CLR_ACC;
  logic              INSTR_DONE;
  logic [15:0]       INSTR_CNT;
  logic              BUSY;
  logic              STOP_SIGNAL;
  logic              ERR_TIMEOUT;

  // Sequencer side
  modport master (
    input  START_SIGNAL, INSTR, OP_DONE, ABORT,
    output PC_INCR, OP_START, OP_CODE, LANE_EN, ADDRESS, DIMEN, CLR_ACC,
           INSTR_DONE, INSTR_CNT, BUSY, STOP_SIGNAL, ERR_TIMEOUT
  );

  // Environment side (instruction memory, PE array, host)
  modport slave (
    output START_SIGNAL, INSTR, OP_DONE, ABORT,
    input  PC_INCR, OP_START, OP_CODE, LANE_EN, ADDRESS, DIMEN, CLR_ACC,
           INSTR_DONE, INSTR_CNT, BUSY, STOP_SIGNAL, ERR_TIMEOUT
  );

endinterface

// File: rtl/simd_seq_ctrl.sv
// SIMD sequencer controller: fetches instructions, issues them to a set of
// PE lanes, waits for every enabled lane to report completion, and counts
// completed instructions. All outputs are registered.
// Optional feature: define SIMD_SEQ_WATCHDOG_EN to bound the WAIT state with
// a TIMEOUT-cycle watchdog that parks the sequencer in ERROR.
module simd_seq_ctrl #(
  parameter int unsigned NUM_PE  = 4,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RSTN,
  simd_seq_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [2:0] OPC_NOP0 = 3'd0;
  localparam logic [2:0] OPC_NOP1 = 3'd1;
  localparam logic [2:0] OPC_HALT = 3'd6;

  localparam int unsigned CNT_W = 16;

  logic [2:0]        state, state_nxt;
  logic [NUM_PE-1:0] sticky, sticky_nxt;

  logic              pc_incr, op_start, instr_done, busy, stop_signal;
  logic [CNT_W-1:0]  instr_cnt, instr_cnt_nxt;
  logic [2:0]        op_code, op_code_nxt;
  logic [NUM_PE-1:0] lane_en, lane_en_nxt;
  logic [ADDR_W-1:0] address, address_nxt;
  logic [1:0]        dimen, dimen_nxt;
  logic              clr_acc, clr_acc_nxt;
  logic              instr_done_nxt;

  // Instruction field decode (used only while in FETCH)
  logic [2:0]        f_opcode;
  logic [1:0]        f_dimen;
  logic              f_clr;
  logic [NUM_PE-1:0] f_mask;
  logic [ADDR_W-1:0] f_addr;
  logic              unused_instr;

  assign f_opcode     = bus.INSTR[2:0];
  assign f_dimen      = bus.INSTR[4:3];
  assign f_clr        = bus.INSTR[5];
  assign f_mask       = bus.INSTR[6 +: NUM_PE];
  assign f_addr       = bus.INSTR[31 -: ADDR_W];
  assign unused_instr = ^bus.INSTR;

  // All enabled lanes have reported, counting this cycle's pulses
  logic complete_c;
  assign complete_c = (((sticky | bus.OP_DONE) & lane_en) == lane_en);

  // Watchdog expiry in the current WAIT cycle
  logic wd_expire_c;

`ifdef SIMD_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic            err_timeout;

  // Expires when this WAIT cycle would bring the count to TIMEOUT-1
  assign wd_expire_c = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT - 2));

  // Watchdog count: cleared on issue, advanced once per WAIT cycle
  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (state == S_ISSUE) begin
      wd_cnt_nxt = '0;
    end else if (state == S_WAIT) begin
      wd_cnt_nxt = wd_cnt + WD_W'(1);
    end
  end

  // Watchdog counter and timeout flag registers
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt      <= wd_cnt_nxt;
      err_timeout <= (state_nxt == S_ERROR);
    end
  end

  assign bus.ERR_TIMEOUT = err_timeout;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;

  assign wd_expire_c     = 1'b0;
  assign bus.ERR_TIMEOUT = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    sticky_nxt     = sticky;
    op_code_nxt    = op_code;
    lane_en_nxt    = lane_en;
    address_nxt    = address;
    dimen_nxt      = dimen;
    clr_acc_nxt    = clr_acc;
    instr_done_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.START_SIGNAL) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        op_code_nxt = f_opcode;
        lane_en_nxt = f_mask;
        address_nxt = f_addr;
        dimen_nxt   = f_dimen;
        clr_acc_nxt = f_clr;
        if (f_opcode == OPC_HALT) begin
          state_nxt = S_STOP;
        end else if ((f_opcode == OPC_NOP0) || (f_opcode == OPC_NOP1) ||
                     (f_mask == '0)) begin
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sticky_nxt = bus.OP_DONE & lane_en;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        sticky_nxt = sticky | (bus.OP_DONE & lane_en);
        if (complete_c) begin
          instr_done_nxt = 1'b1;
          state_nxt      = S_FETCH;
        end else if (wd_expire_c) begin
          state_nxt = S_ERROR;
        end
      end
      S_STOP, S_ERROR: begin
        state_nxt = state;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides completion and timeout in every active state
    if ((state != S_IDLE) && bus.ABORT) begin
      state_nxt      = S_IDLE;
      sticky_nxt     = '0;
      instr_done_nxt = 1'b0;
      op_code_nxt    = op_code;
      lane_en_nxt    = lane_en;
      address_nxt    = address;
      dimen_nxt      = dimen;
      clr_acc_nxt    = clr_acc;
    end
  end

  assign instr_cnt_nxt = instr_cnt + CNT_W'(instr_done_nxt);

  // State, sticky-done, latched fields and output registers
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state       <= S_IDLE;
      sticky      <= '0;
      pc_incr     <= 1'b0;
      op_start    <= 1'b0;
      instr_done  <= 1'b0;
      busy        <= 1'b0;
      stop_signal <= 1'b0;
      instr_cnt   <= '0;
      op_code     <= '0;
      lane_en     <= '0;
      address     <= '0;
      dimen       <= '0;
      clr_acc     <= 1'b0;
    end else begin
      state       <= state_nxt;
      sticky      <= sticky_nxt;
      pc_incr     <= (state_nxt == S_FETCH);
      op_start    <= (state_nxt == S_ISSUE);
      instr_done  <= instr_done_nxt;
      busy        <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE) ||
                     (state_nxt == S_WAIT);
      stop_signal <= (state_nxt == S_STOP);
      instr_cnt   <= instr_cnt_nxt;
      op_code     <= op_code_nxt;
      lane_en     <= lane_en_nxt;
      address     <= address_nxt;
      dimen       <= dimen_nxt;
      clr_acc     <= clr_acc_nxt;
    end
  end

  assign bus.PC_INCR     = pc_incr;
  assign bus.OP_START    = op_start;
  assign bus.OP_CODE     = op_code;
  assign bus.LANE_EN     = lane_en;
  assign bus.ADDRESS     = address;
  assign bus.DIMEN       = dimen;
  assign bus.CLR_ACC     = clr_acc;
  assign bus.INSTR_DONE  = instr_done;
  assign bus.INSTR_CNT   = instr_cnt;
  assign bus.BUSY        = busy;
  assign bus.STOP_SIGNAL = stop_signal;

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// Testbench for simd_seq_ctrl: directed scenarios plus randomized instruction
// streams checked against a transaction-level completion model.
// Define SIMD_SEQ_WATCHDOG_EN to exercise the watchdog scenarios.
module tb_simd_seq_ctrl;

  localparam int unsigned NPE = 4;
  localparam int unsigned AW  = 17;
`ifdef SIMD_SEQ_WATCHDOG_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic CLK = 1'b0;
  logic RSTN;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = '0;

  simd_seq_ctrl_if #(.NUM_PE(NPE), .ADDR_W(AW)) bus ();

  simd_seq_ctrl #(.NUM_PE(NPE), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] opc, input logic [1:0] dim,
                                           input logic clr, input logic [3:0] mask,
                                           input logic [16:0] addr);
    return {addr, 5'b00000, mask, clr, dim, opc};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_pc"},    32'(bus.PC_INCR),     32'd0);
    chk({tag, "_start"}, 32'(bus.OP_START),    32'd0);
    chk({tag, "_done"},  32'(bus.INSTR_DONE),  32'd0);
    chk({tag, "_busy"},  32'(bus.BUSY),        32'd0);
    chk({tag, "_stop"},  32'(bus.STOP_SIGNAL), 32'd0);
    chk({tag, "_err"},   32'(bus.ERR_TIMEOUT), 32'd0);
  endtask

  // Park in STOP via a halt instruction fetched this cycle, then abort
  task automatic halt_and_abort(input string tag);
    bus.INSTR = mk_instr(3'd6, 2'd0, 1'b0, 4'h0, 17'h0);
    step();
    chk({tag, "_stop"}, 32'(bus.STOP_SIGNAL), 32'd1);
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    chk({tag, "_abort_stop"}, 32'(bus.STOP_SIGNAL), 32'd0);
    chk({tag, "_abort_busy"}, 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    int pc_pulses;
    int st_pulses;
    logic [31:0] ins;
    logic [2:0]  opc;
    logic [3:0]  mask;
    logic [1:0]  dim;
    logic        clr;
    logic [16:0] addr;
    int          lane_at [NPE];
    int          c_done;
    logic [3:0]  od;

    RSTN             = 1'b1;
    bus.START_SIGNAL = 1'b0;
    bus.INSTR        = '0;
    bus.OP_DONE      = '0;
    bus.ABORT        = 1'b0;
    step();
    step();
    RSTN = 1'b0;
    chk_quiet("reset");
    chk("reset_cnt",  32'(bus.INSTR_CNT), 32'd0);
    chk("reset_lane", 32'(bus.LANE_EN),   32'd0);
    chk("reset_addr", 32'(bus.ADDRESS),   32'd0);

    // Single issue, all lanes finish in cycle 5
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd4, 2'd2, 1'b1, 4'b1111, 17'h1ABCD);
    step();                                       // cycle 1
    bus.START_SIGNAL = 1'b0;
    chk("c32_pc1",    32'(bus.PC_INCR),  32'd1);
    chk("c32_busy1",  32'(bus.BUSY),     32'd1);
    chk("c32_start1", 32'(bus.OP_START), 32'd0);
    step();                                       // cycle 2
    bus.INSTR = 32'hFFFF_FFFF;
    chk("c32_start2", 32'(bus.OP_START), 32'd1);
    chk("c32_pc2",    32'(bus.PC_INCR),  32'd0);
    chk("c32_opc",    32'(bus.OP_CODE),  32'd4);
    chk("c32_lane",   32'(bus.LANE_EN),  32'hF);
    chk("c32_addr",   32'(bus.ADDRESS),  32'h1ABCD);
    chk("c32_dim",    32'(bus.DIMEN),    32'd2);
    chk("c32_clr",    32'(bus.CLR_ACC),  32'd1);
    step();                                       // cycle 3
    chk("c32_start3", 32'(bus.OP_START),   32'd0);
    chk("c32_done3",  32'(bus.INSTR_DONE), 32'd0);
    step();                                       // cycle 4
    chk("c32_done4",  32'(bus.INSTR_DONE), 32'd0);
    chk("c32_hold",   32'(bus.ADDRESS),    32'h1ABCD);
    step();                                       // cycle 5
    bus.OP_DONE = 4'hF;
    chk("c32_done5",  32'(bus.INSTR_DONE), 32'd0);
    step();                                       // cycle 6
    bus.OP_DONE = '0;
    exp_cnt++;
    chk("c32_done6",  32'(bus.INSTR_DONE), 32'd1);
    chk("c32_cnt",    32'(bus.INSTR_CNT),  32'(exp_cnt));
    chk("c32_pc6",    32'(bus.PC_INCR),    32'd1);
    halt_and_abort("c32");

    // Partial mask; pulse on a disabled lane must be ignored
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd3, 2'd1, 1'b0, 4'b0101, 17'h00042);
    step();                                       // cycle 1
    bus.START_SIGNAL = 1'b0;
    step();                                       // cycle 2
    chk("c33_start", 32'(bus.OP_START), 32'd1);
    chk("c33_lane",  32'(bus.LANE_EN),  32'h5);
    for (int cyc = 3; cyc <= 6; cyc++) begin
      step();
      bus.OP_DONE = (cyc == 3) ? 4'b0001 : (cyc == 4) ? 4'b0010 :
                    (cyc == 6) ? 4'b0100 : 4'b0000;
      chk($sformatf("c33_done%0d", cyc), 32'(bus.INSTR_DONE), 32'd0);
    end
    step();                                       // cycle 7
    bus.OP_DONE = '0;
    exp_cnt++;
    chk("c33_done7", 32'(bus.INSTR_DONE), 32'd1);
    chk("c33_cnt",   32'(bus.INSTR_CNT),  32'(exp_cnt));
    bus.INSTR = mk_instr(3'd6, 2'd0, 1'b0, 4'h0, 17'h0);
    step();                                       // cycle 8
    chk("c33_once", 32'(bus.INSTR_DONE), 32'd0);
    chk("c33_stop", 32'(bus.STOP_SIGNAL), 32'd1);
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;

    // NOP then halt: two fetches, no issue, STOP held until abort
    pc_pulses = 0;
    st_pulses = 0;
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd0, 2'd0, 1'b0, 4'hF, 17'h0);
    step();                                       // cycle 1
    bus.START_SIGNAL = 1'b0;
    pc_pulses += int'(bus.PC_INCR);
    st_pulses += int'(bus.OP_START);
    step();                                       // cycle 2
    bus.INSTR = mk_instr(3'd6, 2'd0, 1'b0, 4'hF, 17'h0);
    pc_pulses += int'(bus.PC_INCR);
    st_pulses += int'(bus.OP_START);
    for (int i = 0; i < 20; i++) begin
      step();
      pc_pulses += int'(bus.PC_INCR);
      st_pulses += int'(bus.OP_START);
      chk("c34_stop_held", 32'(bus.STOP_SIGNAL), 32'd1);
    end
    chk("c34_pc_pulses",    32'(pc_pulses), 32'd2);
    chk("c34_start_pulses", 32'(st_pulses), 32'd0);
    chk("c34_busy", 32'(bus.BUSY), 32'd0);
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    chk_quiet("c34_abort");
    chk("c34_cnt", 32'(bus.INSTR_CNT), 32'(exp_cnt));

`ifdef SIMD_SEQ_WATCHDOG_EN
    // No completion: error after 7 WAIT cycles (WAIT spans cycles 3..9)
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd5, 2'd0, 1'b0, 4'b0011, 17'h7);
    step();
    bus.START_SIGNAL = 1'b0;
    step();                                       // cycle 2 (issue)
    for (int cyc = 3; cyc <= 9; cyc++) begin
      step();
      chk("wd_no_err_yet", 32'(bus.ERR_TIMEOUT), 32'd0);
      chk("wd_busy",       32'(bus.BUSY),        32'd1);
    end
    step();                                       // cycle 10
    chk("wd_err", 32'(bus.ERR_TIMEOUT), 32'd1);
    chk("wd_err_busy", 32'(bus.BUSY), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("wd_err_held", 32'(bus.ERR_TIMEOUT), 32'd1);
    bus.OP_DONE = 4'hF;
    bus.ABORT   = 1'b1;
    step();
    bus.OP_DONE = '0;
    bus.ABORT   = 1'b0;
    chk_quiet("wd_abort");

    // Completion on the 7th WAIT cycle wins over the watchdog
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd5, 2'd0, 1'b0, 4'b0011, 17'h7);
    step();
    bus.START_SIGNAL = 1'b0;
    step();
    bus.INSTR = mk_instr(3'd6, 2'd0, 1'b0, 4'h0, 17'h0);
    for (int cyc = 3; cyc <= 9; cyc++) begin
      step();
      if (cyc == 9) bus.OP_DONE = 4'b0011;
    end
    step();                                       // cycle 10
    bus.OP_DONE = '0;
    exp_cnt++;
    chk("wd_race_done", 32'(bus.INSTR_DONE),  32'd1);
    chk("wd_race_err",  32'(bus.ERR_TIMEOUT), 32'd0);
    chk("wd_race_cnt",  32'(bus.INSTR_CNT),   32'(exp_cnt));
    step();
    chk("wd_race_stop", 32'(bus.STOP_SIGNAL), 32'd1);
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
`else
    // Without the watchdog WAIT is unbounded
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd2, 2'd0, 1'b0, 4'hF, 17'h3);
    step();
    bus.START_SIGNAL = 1'b0;
    step();
    for (int i = 0; i < 40; i++) step();
    chk("nowd_err",  32'(bus.ERR_TIMEOUT), 32'd0);
    chk("nowd_busy", 32'(bus.BUSY),        32'd1);
    bus.OP_DONE = 4'hF;
    step();
    bus.OP_DONE = '0;
    exp_cnt++;
    chk("nowd_done", 32'(bus.INSTR_DONE), 32'd1);
    halt_and_abort("nowd");
`endif

    // Abort in the completion cycle suppresses the completion
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd2, 2'd0, 1'b0, 4'hF, 17'h9);
    step();
    bus.START_SIGNAL = 1'b0;
    step();
    step();                                       // WAIT
    bus.OP_DONE = 4'hF;
    bus.ABORT   = 1'b1;
    step();
    bus.OP_DONE = '0;
    bus.ABORT   = 1'b0;
    chk_quiet("abort_wins");
    chk("abort_wins_cnt", 32'(bus.INSTR_CNT), 32'(exp_cnt));

    // Randomized instruction stream against the completion model
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd0, 2'd0, 1'b0, 4'h0, 17'h0);
    step();
    bus.START_SIGNAL = 1'b0;
    for (int n = 0; n < 60; n++) begin
      chk("rnd_fetch_pc", 32'(bus.PC_INCR), 32'd1);
      do opc = 3'($urandom_range(0, 7)); while (opc == 3'd6);
      mask = 4'($urandom_range(0, 15));
      dim  = 2'($urandom_range(0, 3));
      clr  = 1'($urandom_range(0, 1));
      addr = 17'($urandom);
      ins  = mk_instr(opc, dim, clr, mask, addr);
      bus.INSTR = ins;
      step();
      if (opc <= 3'd1 || mask == 4'h0) begin
        chk("rnd_nop_start", 32'(bus.OP_START), 32'd0);
        continue;
      end
      chk("rnd_start", 32'(bus.OP_START), 32'd1);
      chk("rnd_opc",   32'(bus.OP_CODE),  32'(opc));
      chk("rnd_lane",  32'(bus.LANE_EN),  32'(mask));
      chk("rnd_addr",  32'(bus.ADDRESS),  32'(addr));
      chk("rnd_dim",   32'(bus.DIMEN),    32'(dim));
      chk("rnd_clr",   32'(bus.CLR_ACC),  32'(clr));
      // Each enabled lane reports once, 0..5 cycles after issue; completion
      // is seen in the cycle the last one arrives (never before first WAIT)
      c_done = 1;
      for (int j = 0; j < NPE; j++) begin
        lane_at[j] = $urandom_range(0, 5);
        if (mask[j] && lane_at[j] > c_done) c_done = lane_at[j];
      end
      for (int k = 0; k <= c_done; k++) begin
        if (k > 0) begin
          chk("rnd_wait_done", 32'(bus.INSTR_DONE), 32'd0);
          chk("rnd_wait_busy", 32'(bus.BUSY),       32'd1);
          chk("rnd_stable",    32'(bus.ADDRESS),    32'(addr));
        end
        od = 4'($urandom_range(0, 15)) & ~mask;
        for (int j = 0; j < NPE; j++) begin
          if (mask[j] && lane_at[j] == k) od[j] = 1'b1;
        end
        bus.OP_DONE = od;
        bus.INSTR   = $urandom;
        step();
      end
      bus.OP_DONE = '0;
      exp_cnt++;
      chk("rnd_done", 32'(bus.INSTR_DONE), 32'd1);
      chk("rnd_cnt",  32'(bus.INSTR_CNT),  32'(exp_cnt));
    end
    halt_and_abort("rnd");

    // Reset in the middle of WAIT discards the pending instruction
    bus.START_SIGNAL = 1'b1;
    bus.INSTR = mk_instr(3'd7, 2'd3, 1'b1, 4'hF, 17'h1FFFF);
    step();
    bus.START_SIGNAL = 1'b0;
    step();                                       // issue
    step();                                       // WAIT
    RSTN        = 1'b1;
    bus.OP_DONE = 4'hF;
    step();
    RSTN    = 1'b0;
    exp_cnt = '0;
    chk_quiet("rst_wait");
    chk("rst_wait_cnt",  32'(bus.INSTR_CNT), 32'(exp_cnt));
    chk("rst_wait_lane", 32'(bus.LANE_EN),   32'd0);
    step();
    bus.OP_DONE = '0;
    chk_quiet("rst_after");
    chk("rst_after_cnt", 32'(bus.INSTR_CNT), 32'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
